param_reg_bank: RTL and testbench
=================================

# param_reg_bank

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits, sharing one FunSel operation code and a data input. It generalises the single 16-bit FunSel register to arbitrary width and register count, and adds per-register enables, two independent read ports, an optional saturating increment/decrement mode and sticky per-register wrap/limit flags. It sits in the datapath as the general-purpose/address register file feeding the ALU and memory address muxes.

## Interface
- WIDTH, 16, register width in bits; even, >= 8; HALF = WIDTH/2
- NUM_REGS, 4, number of registers; >= 2
- SATURATE, 0, 0 = increment/decrement wraps modulo 2^WIDTH; 1 = clamps at all-ones / zero
- SELW, $clog2(NUM_REGS), read-select width (derived)

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- I  in  WIDTH  write data
- E  in  NUM_REGS  per-register enable; bit k enables register k; any number may be high
- FunSel  in  3  operation applied to every enabled register
- OutASel  in  SELW  read port A select
- OutBSel  in  SELW  read port B select
- OutA  out  WIDTH  contents of register OutASel
- OutB  out  WIDTH  contents of register OutBSel
- Lim  out  NUM_REGS  sticky wrap/limit flag per register

## Operation
- Reset high (any time, independent of Clock): all registers = 0, Lim = 0; held while Reset high.
- On rising Clock, for each k with E[k]=1, register R[k] updates per FunSel:
  - 000: decrement. SATURATE=0: R-1 mod 2^WIDTH. SATURATE=1: R=0 stays 0.
  - 001: increment. SATURATE=0: R+1 mod 2^WIDTH. SATURATE=1: all-ones stays all-ones.
  - 010: R = I.
  - 011: R = 0; Lim[k] cleared.
  - 100: R = {HALF zeros, I[HALF-1:0]}.
  - 101: R[HALF-1:0] = I[HALF-1:0]; upper half unchanged.
  - 110: R[WIDTH-1:HALF] = I[HALF-1:0]; lower half unchanged.
  - 111: R = sign-extended I[HALF-1:0] (replicate I[HALF-1]).
- Registers with E[k]=0 hold value and Lim[k].
- Lim[k] set (same edge) when E[k]=1 and either FunSel=000 with R[k]=0, or FunSel=001 with R[k]=all-ones; applies in both SATURATE modes. Lim[k] otherwise holds; only FunSel 011 on register k or Reset clears it. Setting and clearing never coincide (disjoint FunSel).
- Multiple enables: each selected register computes from its own current value; no cross-register interaction.
- Read ports: OutA = R[OutASel], OutB = R[OutBSel], combinational from register state; both ports may select the same register. Select >= NUM_REGS drives 0.

## Timing
- Write latency 1 cycle: value written at edge n visible on OutA/OutB after edge n (same cycle, after clock-to-Q); no write-through of I.
- Read ports change combinationally with OutASel/OutBSel.
- Lim updates on the same edge as its register.
- E and FunSel sampled only at rising Clock; changes between edges have no effect.
- Reset asserted mid-sequence: outputs go to 0 immediately, no edge needed; first operation executes on the first rising edge with Reset low.
- Reset deasserted coincident with a rising edge: that edge is ignored; requirement is deassertion at least setup time before the next edge.

## Test plan
- Reset with all registers loaded to 0xBEEF, Reset=1 mid-cycle -> OutA=OutB=0x0000 and Lim=0000 before next edge.
- E=0101, FunSel=010, I=0x1234, then OutASel=0, OutBSel=2 -> OutA=OutB=0x1234; R1, R3 remain 0.
- R1=0xFFFF, SATURATE=0, E=0010, FunSel=001 -> R1=0x0000, Lim=0010; next FunSel=011 on R1 -> Lim=0000.
- SATURATE=1: R2=0x0000, E=0100, FunSel=000 twice -> R2 stays 0x0000, Lim[2]=1; FunSel=001 -> R2=0x0001, Lim[2] still 1.
- R0=0xABCD: FunSel=101, I=0x0012 -> 0xAB12; FunSel=110, I=0x0034 -> 0x3412; FunSel=111, I=0x0080 -> 0xFF80; FunSel=100, I=0x0180 -> 0x0080.
- WIDTH=8, NUM_REGS=3: OutASel=3 -> OutA=0x00; R0=0x0F, FunSel=111, I=0x0F -> R0=0xFF (HALF=4 sign-extension).

Source files
------------

// File: rtl/param_reg_bank_if.sv
// Bus bundle for param_reg_bank: write data, per-register enables, op code,
// the two read selects and the read/limit results.
interface param_reg_bank_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter int SELW     = $clog2(NUM_REGS)
) ();
    logic [WIDTH-1:0]    I;
    logic [NUM_REGS-1:0] E;
    logic [2:0]          FunSel;
    logic [SELW-1:0]     OutASel;
    logic [SELW-1:0]     OutBSel;
    logic [WIDTH-1:0]    OutA;
    logic [WIDTH-1:0]    OutB;
    logic [NUM_REGS-1:0] Lim;

    modport master (
        output I, E, FunSel, OutASel, OutBSel,
        input  OutA, OutB, Lim
    );

    modport slave (
        input  I, E, FunSel, OutASel, OutBSel,
        output OutA, OutB, Lim
    );
endinterface

// File: rtl/param_reg_bank.sv
// General-purpose register bank: NUM_REGS x WIDTH registers sharing one FunSel
// op, two combinational read ports and sticky per-register wrap/limit flags.
module param_reg_bank #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter int SATURATE = 0,
    parameter int SELW     = $clog2(NUM_REGS)
) (
    input  logic             Clock,
    input  logic             Reset,
    param_reg_bank_if.slave  bus
);
    localparam int HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_lim;
    logic [WIDTH-1:0]    w_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_lim_next;
    logic [WIDTH-1:0]    w_out_a;
    logic [WIDTH-1:0]    w_out_b;

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            w_next[k]     = r_regs[k];
            w_lim_next[k] = r_lim[k];
            if (bus.E[k]) begin
                case (bus.FunSel)
                    3'b000: begin
                        // At zero the flag fires in both modes; only the value differs
                        if (r_regs[k] == '0) begin
                            w_lim_next[k] = 1'b1;
                            w_next[k]     = (SATURATE != 0) ? '0 : ALL_ONES;
                        end else begin
                            w_next[k] = r_regs[k] - ONE;
                        end
                    end
                    3'b001: begin
                        if (r_regs[k] == ALL_ONES) begin
                            w_lim_next[k] = 1'b1;
                            w_next[k]     = (SATURATE != 0) ? ALL_ONES : '0;
                        end else begin
                            w_next[k] = r_regs[k] + ONE;
                        end
                    end
                    3'b010: w_next[k] = bus.I;
                    3'b011: begin
                        w_next[k]     = '0;
                        w_lim_next[k] = 1'b0;
                    end
                    3'b100: w_next[k] = {{HALF{1'b0}}, bus.I[HALF-1:0]};
                    3'b101: w_next[k] = {r_regs[k][WIDTH-1:HALF], bus.I[HALF-1:0]};
                    3'b110: w_next[k] = {bus.I[HALF-1:0], r_regs[k][HALF-1:0]};
                    default: w_next[k] = {{HALF{bus.I[HALF-1]}}, bus.I[HALF-1:0]};
                endcase
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_lim <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= w_next[k];
            end
            r_lim <= w_lim_next;
        end
    end

    // Out-of-range selects fall through to zero
    always_comb begin
        w_out_a = '0;
        w_out_b = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(bus.OutASel) == k) w_out_a = r_regs[k];
            if (int'(bus.OutBSel) == k) w_out_b = r_regs[k];
        end
    end

    assign bus.OutA = w_out_a;
    assign bus.OutB = w_out_b;
    assign bus.Lim  = r_lim;
endmodule

// File: tb/tb_param_reg_bank.sv
// Scoreboard bench for param_reg_bank: three configurations (16x4 wrap,
// 16x4 saturate, 8x3 wrap) driven with directed vectors.
module tb_param_reg_bank;
    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    param_reg_bank_if #(.WIDTH(16), .NUM_REGS(4)) bus0 ();
    param_reg_bank_if #(.WIDTH(16), .NUM_REGS(4)) bus1 ();
    param_reg_bank_if #(.WIDTH(8),  .NUM_REGS(3)) bus2 ();

    param_reg_bank #(.WIDTH(16), .NUM_REGS(4), .SATURATE(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .bus(bus0.slave));
    param_reg_bank #(.WIDTH(16), .NUM_REGS(4), .SATURATE(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .bus(bus1.slave));
    param_reg_bank #(.WIDTH(8),  .NUM_REGS(3), .SATURATE(0)) dut2 (
        .Clock(Clock), .Reset(Reset), .bus(bus2.slave));

    typedef struct {
        int          d;
        int          k;
        logic [15:0] exp;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [15:0] get_act(int d, int k);
        logic [15:0] v;
        v = 16'hDEAD;
        case (d)
            0: case (k)
                   0: v = bus0.OutA;
                   1: v = bus0.OutB;
                   default: v = 16'(bus0.Lim);
               endcase
            1: case (k)
                   0: v = bus1.OutA;
                   1: v = bus1.OutB;
                   default: v = 16'(bus1.Lim);
               endcase
            default: case (k)
                   0: v = 16'(bus2.OutA);
                   1: v = 16'(bus2.OutB);
                   default: v = 16'(bus2.Lim);
               endcase
        endcase
        return v;
    endfunction

    // Monitor: drains the scoreboard away from the active edge
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge Clock);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = get_act(e.d, e.k);
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
                end
            end
        end
    end

    task automatic op(int d, logic [3:0] e, logic [2:0] f, logic [15:0] i);
        case (d)
            0: begin bus0.E = e;      bus0.FunSel = f; bus0.I = i;      end
            1: begin bus1.E = e;      bus1.FunSel = f; bus1.I = i;      end
            default: begin bus2.E = e[2:0]; bus2.FunSel = f; bus2.I = i[7:0]; end
        endcase
        @(posedge Clock);
        #1;
        bus0.E = '0;
        bus1.E = '0;
        bus2.E = '0;
    endtask

    // k: 0 = port A, 1 = port B, 2 = Lim vector
    task automatic chk(int d, int k, int sel, logic [15:0] exp, string nm);
        exp_t e;
        case (d)
            0: if (k == 0) bus0.OutASel = 2'(sel); else if (k == 1) bus0.OutBSel = 2'(sel);
            1: if (k == 0) bus1.OutASel = 2'(sel); else if (k == 1) bus1.OutBSel = 2'(sel);
            default: if (k == 0) bus2.OutASel = 2'(sel); else if (k == 1) bus2.OutBSel = 2'(sel);
        endcase
        e.d = d; e.k = k; e.exp = exp; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic settle();
        @(negedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        bus0.E = '0; bus0.FunSel = '0; bus0.I = '0; bus0.OutASel = '0; bus0.OutBSel = '0;
        bus1.E = '0; bus1.FunSel = '0; bus1.I = '0; bus1.OutASel = '0; bus1.OutBSel = '0;
        bus2.E = '0; bus2.FunSel = '0; bus2.I = '0; bus2.OutASel = '0; bus2.OutBSel = '0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        chk(0, 0, 0, 16'h0000, "reset_r0");
        chk(0, 2, 0, 16'h0000, "reset_lim");
        settle();

        // Load all with BEEF, then reset mid-cycle: must clear without an edge
        op(0, 4'b1111, 3'b010, 16'hBEEF);
        chk(0, 0, 3, 16'hBEEF, "load_r3");
        chk(0, 1, 1, 16'hBEEF, "load_r1");
        settle();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        chk(0, 0, 0, 16'h0000, "async_rst_a");
        chk(0, 1, 3, 16'h0000, "async_rst_b");
        chk(0, 2, 0, 16'h0000, "async_rst_lim");
        settle();
        Reset = 1'b0;
        settle();

        op(0, 4'b0101, 3'b010, 16'h1234);
        chk(0, 0, 0, 16'h1234, "multi_load_r0");
        chk(0, 1, 2, 16'h1234, "multi_load_r2");
        settle();
        chk(0, 0, 1, 16'h0000, "unen_r1");
        chk(0, 1, 3, 16'h0000, "unen_r3");
        settle();

        // Wrap on increment sets Lim, clear op drops it
        op(0, 4'b0010, 3'b010, 16'hFFFF);
        op(0, 4'b0010, 3'b001, 16'h0000);
        chk(0, 0, 1, 16'h0000, "inc_wrap_r1");
        chk(0, 2, 0, 16'h0002, "inc_wrap_lim");
        settle();
        op(0, 4'b0010, 3'b011, 16'h0000);
        chk(0, 2, 0, 16'h0000, "clr_lim");
        settle();
        op(0, 4'b1000, 3'b000, 16'h0000);
        chk(0, 0, 3, 16'hFFFF, "dec_wrap_r3");
        chk(0, 2, 0, 16'h0008, "dec_wrap_lim");
        settle();

        // Saturating bank
        op(1, 4'b0100, 3'b000, 16'h0000);
        op(1, 4'b0100, 3'b000, 16'h0000);
        chk(1, 0, 2, 16'h0000, "sat_dec_r2");
        chk(1, 2, 0, 16'h0004, "sat_dec_lim");
        settle();
        op(1, 4'b0100, 3'b001, 16'h0000);
        chk(1, 0, 2, 16'h0001, "sat_inc_r2");
        chk(1, 2, 0, 16'h0004, "sat_lim_sticky");
        settle();
        op(1, 4'b0001, 3'b010, 16'hFFFF);
        op(1, 4'b0001, 3'b001, 16'h0000);
        chk(1, 1, 0, 16'hFFFF, "sat_inc_top");
        chk(1, 2, 0, 16'h0005, "sat_inc_lim");
        settle();

        // Half-word ops on R0
        op(0, 4'b0001, 3'b010, 16'hABCD);
        op(0, 4'b0001, 3'b101, 16'h0012);
        chk(0, 0, 0, 16'hAB12, "lo_half");
        settle();
        op(0, 4'b0001, 3'b110, 16'h0034);
        chk(0, 0, 0, 16'h3412, "hi_half");
        settle();
        op(0, 4'b0001, 3'b111, 16'h0080);
        chk(0, 0, 0, 16'hFF80, "sext");
        settle();
        op(0, 4'b0001, 3'b100, 16'h0180);
        chk(0, 0, 0, 16'h0080, "zext");
        settle();

        // All enabled: each register steps from its own value
        op(0, 4'b1111, 3'b001, 16'h0000);
        chk(0, 0, 0, 16'h0081, "all_inc_r0");
        chk(0, 1, 3, 16'h0000, "all_inc_r3");
        settle();
        chk(0, 0, 2, 16'h1235, "all_inc_r2");
        chk(0, 1, 1, 16'h0001, "all_inc_r1");
        chk(0, 2, 0, 16'h0008, "all_inc_lim");
        settle();

        // 8-bit x 3 bank
        op(2, 4'b0111, 3'b010, 16'h005A);
        chk(2, 0, 3, 16'h0000, "w8_sel_oob");
        chk(2, 1, 2, 16'h005A, "w8_r2");
        settle();
        op(2, 4'b0001, 3'b010, 16'h000F);
        op(2, 4'b0001, 3'b111, 16'h000F);
        chk(2, 0, 0, 16'h00FF, "w8_sext");
        chk(2, 1, 0, 16'h00FF, "w8_same_sel");
        settle();
        op(2, 4'b0010, 3'b110, 16'h0003);
        chk(2, 0, 1, 16'h003A, "w8_hi_half");
        settle();

        begin
            int budget;
            budget = 20;
            while (q.size() > 0 && budget > 0) begin
                @(posedge Clock);
                budget--;
            end
            if (q.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain: got %0d pending expected 0", q.size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
